cache_line_xfer: RTL and testbench
==================================

Name: cache_line_xfer

Overview:
- Line-transfer engine between the cache controller and MainMemory.
- On a miss it writes back the victim line if dirty, then fills the requested line.
- Each line is BURST_WIDTH words, moved one word per MainMemory RE/WE transaction gated by memValid.
- Cache side: a request/done handshake plus word-indexed read and write ports into the cache data array.

Parameters:
- BURST_WIDTH, 8, words per cache line; power of two, ≥2. OFF = $clog2(BURST_WIDTH); LW = 30-OFF (line-address width).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  1  miss request; sampled only in IDLE.
- DIRTY  in  1  victim line dirty; sampled with REQ.
- VICTIM_LADDR  in  LW  victim line address (word addr [31:2] >> OFF); sampled with REQ.
- MISS_LADDR  in  LW  requested line address; sampled with REQ.
- BUSY  out  1  high from the cycle after accept through the DONE cycle inclusive.
- DONE  out  1  one-cycle pulse; line fill complete.
- WB_IDX  out  OFF  word index into victim line; the cache returns WB_WORD combinationally.
- WB_WORD  in  32  victim word at WB_IDX.
- FILL_WE  out  1  one-cycle write strobe to the cache data array.
- FILL_IDX  out  OFF  word index for the fill write.
- FILL_WORD  out  32  fill data (registered MEM_DOUT).
- MEM_RE  out  1  MainMemory read enable.
- MEM_WE  out  1  MainMemory write enable.
- MEM_ADDR  out  30  MainMemory word address.
- MEM_DATA_IN  out  32  write data to memory.
- MEM_DOUT  in  32  read data from memory.
- memValid  in  1  memory transaction complete; sampled at posedge.

Behaviour:
- Reset (sync, RST=1 at posedge): state IDLE; counter = 0.
- Outputs after reset: BUSY, DONE, FILL_WE, MEM_RE and MEM_WE are 0; WB_IDX, FILL_IDX, MEM_ADDR and FILL_WORD are 0; MEM_DATA_IN = 0.
- RST overrides all other inputs, including mid-transfer. MEM_RE/MEM_WE drop the cycle after the RST edge. DONE is not issued and the partial fill is abandoned.
- States: IDLE, WB, WB_GAP, FILL, FILL_GAP, DONE.
- IDLE:
  - On REQ, latch both line addresses and clear the word counter cnt.
  - Go to WB if DIRTY, else FILL.
- WB:
  - MEM_WE=1, MEM_ADDR={VICTIM_LADDR,cnt}, WB_IDX=cnt, MEM_DATA_IN=WB_WORD.
  - All held stable until memValid is sampled high; then go to WB_GAP.
- WB_GAP:
  - One cycle with MEM_RE=MEM_WE=0.
  - If cnt==BURST_WIDTH-1: cnt←0, go to FILL. Else cnt←cnt+1, back to WB.
- FILL:
  - MEM_RE=1, MEM_ADDR={MISS_LADDR,cnt}, held until memValid is sampled high.
  - On that edge, FILL_WORD←MEM_DOUT and FILL_IDX←cnt; FILL_WE=1 for exactly the following cycle (the FILL_GAP cycle). Go to FILL_GAP.
- FILL_GAP:
  - MEM_RE=MEM_WE=0.
  - If cnt==BURST_WIDTH-1, go to DONE; else cnt←cnt+1, back to FILL.
- DONE:
  - DONE=1 and BUSY=1 for one cycle; then IDLE. A REQ is accepted no earlier than the following IDLE cycle.
- Mutual exclusion: MEM_RE and MEM_WE are never both 1. Every transaction is followed by at least one idle memory cycle.
- Word order: always index 0 to BURST_WIDTH-1; no critical-word-first.
- Counter: wraps only via the explicit clear. MEM_ADDR = line address concatenated with the OFF-bit cnt; no carry into the line address.
- Ignored inputs: REQ, DIRTY and the addresses are ignored while BUSY. Changes to them while BUSY have no effect.
- Latency: if word k's transaction completes Lk cycles after its enable rises, then
  total cycles = 1 (accept) + Σ(Lk+1) over all words moved + 1 (DONE).

Test Plan:
- Clean fill, BURST_WIDTH=8, MainMemory DELAY_CYCLES=10, MISS_LADDR=0x0000002 with DIRTY=0:
  - MEM_RE addresses 0x10..0x17 in order; MEM_WE never 1.
  - 8 FILL_WE pulses, FILL_IDX 0..7, FILL_WORD = otter_mem.mem words 16..23.
  - Single DONE pulse.
- Dirty miss, VICTIM_LADDR=0x1, MISS_LADDR=0x0, WB_WORD = 0xA000_0000 + WB_IDX:
  - First, 8 writes to 0x8..0xF with data 0xA0000000..0xA0000007.
  - Then 8 reads from 0x0..0x7. A later clean fill of line 1 returns 0xA0000000..7.
- Handshake timing:
  - Check MEM_ADDR/MEM_DATA_IN stable while MEM_RE|MEM_WE is high.
  - Check a gap cycle after every memValid.
  - Measured total cycles equal the latency formula.
- REQ held high while BUSY, with MISS_LADDR changed mid-transfer:
  - Addresses stay on the original line; a second transfer starts only after DONE.
- RST asserted during the 4th fill word:
  - Next cycle: BUSY=0, MEM_RE=0, no DONE, FILL_WE=0.
  - A subsequent REQ completes normally.
- Back-to-back: REQ on the first IDLE cycle after DONE is accepted; no cycles lost beyond the formula.

Source files
------------

// File: rtl/cache_line_xfer.sv
// Cache line transfer engine: optional dirty-victim writeback followed by a line fill,
// one word per MainMemory transaction, with an idle memory cycle after every memValid.
module cache_line_xfer #(
  parameter  int BURST_WIDTH = 8,
  localparam int OFF         = $clog2(BURST_WIDTH),
  localparam int LW          = 30 - OFF
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           REQ,
  input  logic           DIRTY,
  input  logic [LW-1:0]  VICTIM_LADDR,
  input  logic [LW-1:0]  MISS_LADDR,
  output logic           BUSY,
  output logic           DONE,
  output logic [OFF-1:0] WB_IDX,
  input  logic [31:0]    WB_WORD,
  output logic           FILL_WE,
  output logic [OFF-1:0] FILL_IDX,
  output logic [31:0]    FILL_WORD,
  output logic           MEM_RE,
  output logic           MEM_WE,
  output logic [29:0]    MEM_ADDR,
  output logic [31:0]    MEM_DATA_IN,
  input  logic [31:0]    MEM_DOUT,
  input  logic           memValid
);

  localparam logic [OFF-1:0] LAST = OFF'(BURST_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_WB_GAP, S_FILL, S_FILL_GAP, S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [OFF-1:0] r_cnt;
  logic [LW-1:0]  r_victim;
  logic [LW-1:0]  r_miss;
  logic           r_fill_we;
  logic [OFF-1:0] r_fill_idx;
  logic [31:0]    r_fill_word;
  logic           w_last;

  assign w_last = (r_cnt == LAST);

  // Memory-side outputs decode straight from state so a reset edge drops RE/WE
  // in the very next cycle.
  always_comb begin
    w_next      = r_state;
    BUSY        = (r_state != S_IDLE);
    DONE        = 1'b0;
    MEM_RE      = 1'b0;
    MEM_WE      = 1'b0;
    MEM_ADDR    = '0;
    MEM_DATA_IN = '0;
    case (r_state)
      S_IDLE: begin
        if (REQ) w_next = DIRTY ? S_WB : S_FILL;
      end
      S_WB: begin
        MEM_WE      = 1'b1;
        MEM_ADDR    = {r_victim, r_cnt};
        MEM_DATA_IN = WB_WORD;
        if (memValid) w_next = S_WB_GAP;
      end
      S_WB_GAP: begin
        w_next = w_last ? S_FILL : S_WB;
      end
      S_FILL: begin
        MEM_RE   = 1'b1;
        MEM_ADDR = {r_miss, r_cnt};
        if (memValid) w_next = S_FILL_GAP;
      end
      S_FILL_GAP: begin
        w_next = w_last ? S_DONE : S_FILL;
      end
      S_DONE: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_victim    <= '0;
      r_miss      <= '0;
      r_fill_we   <= 1'b0;
      r_fill_idx  <= '0;
      r_fill_word <= '0;
    end else begin
      r_state   <= w_next;
      r_fill_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (REQ) begin
            r_victim <= VICTIM_LADDR;
            r_miss   <= MISS_LADDR;
            r_cnt    <= '0;
          end
        end
        S_WB_GAP: begin
          r_cnt <= w_last ? '0 : r_cnt + OFF'(1);
        end
        S_FILL: begin
          if (memValid) begin
            r_fill_we   <= 1'b1;
            r_fill_idx  <= r_cnt;
            r_fill_word <= MEM_DOUT;
          end
        end
        S_FILL_GAP: begin
          if (!w_last) r_cnt <= r_cnt + OFF'(1);
        end
        // Leave IDLE with the word index back at zero.
        S_DONE: r_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign WB_IDX    = r_cnt;
  assign FILL_WE   = r_fill_we;
  assign FILL_IDX  = r_fill_idx;
  assign FILL_WORD = r_fill_word;

endmodule

// File: tb/tb_cache_line_xfer.sv
// Randomized bench for cache_line_xfer: a transaction-level model predicts the memory
// transaction list, fill writes, BUSY/DONE windows and total latency for each miss.
module tb_cache_line_xfer;
  localparam int BW  = 8;
  localparam int OFF = 3;
  localparam int LW  = 27;

  logic           CLK = 1'b0;
  logic           RST, REQ, DIRTY;
  logic [LW-1:0]  VICTIM_LADDR, MISS_LADDR;
  logic           BUSY, DONE, FILL_WE, MEM_RE, MEM_WE;
  logic [OFF-1:0] WB_IDX, FILL_IDX;
  logic [31:0]    WB_WORD, FILL_WORD, MEM_DATA_IN;
  logic [31:0]    MEM_DOUT = 32'h0;
  logic [29:0]    MEM_ADDR;
  logic           memValid = 1'b0;
  logic [31:0]    wb_base;

  cache_line_xfer #(.BURST_WIDTH(BW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DIRTY(DIRTY),
    .VICTIM_LADDR(VICTIM_LADDR), .MISS_LADDR(MISS_LADDR),
    .BUSY(BUSY), .DONE(DONE), .WB_IDX(WB_IDX), .WB_WORD(WB_WORD),
    .FILL_WE(FILL_WE), .FILL_IDX(FILL_IDX), .FILL_WORD(FILL_WORD),
    .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA_IN(MEM_DATA_IN), .MEM_DOUT(MEM_DOUT), .memValid(memValid)
  );

  always #5 CLK = ~CLK;

  // Cache data array stand-in: victim word k is wb_base + k.
  assign WB_WORD = wb_base + 32'(WB_IDX);

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [31:0] data;
    int          idx;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  logic [31:0] ref_mem [1024];
  logic [31:0] resp_mem[1024];
  logic [31:0] fill_log[BW];
  logic [29:0] first_rd_addr;
  bit          first_rd_set;
  int n_err = 0, n_chk = 0;
  bit busy_m = 0, done_next = 0, was_done = 0;
  int wait_cnt = -1, cur_lat = 0, lat_sum = 0, cyc = 0, last_total = 0;
  int done_cnt = 0, acc_cnt = 0, fills_this = 0, lat_mode = 0;
  logic l_rst = 1'b1, l_req = 1'b0, l_dirty = 1'b0, l_valid = 1'b0, p_en = 1'b0;
  logic [LW-1:0] l_v = '0, l_m = '0;
  logic [29:0]   p_addr = '0;
  logic [31:0]   p_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update, per-cycle compare and memory responder share one process so the
  // order of "check outputs" then "decide memValid" is fixed.
  always @(negedge CLK) begin : monitor
    bit   exp_done, exp_fwe, en;
    logic [29:0] a;
    exp_done = 1'b0;
    exp_fwe  = 1'b0;
    if (l_rst) begin
      busy_m = 0; done_next = 0; was_done = 0; exp_q.delete();
    end else begin
      if (was_done) begin
        busy_m = 0; was_done = 0;
      end else if (!busy_m && l_req) begin
        busy_m = 1; acc_cnt++; cyc = 1; lat_sum = 0; fills_this = 0; first_rd_set = 0;
        if (l_dirty)
          for (int k = 0; k < BW; k++) begin
            a = {l_v, 3'(k)};
            exp_q.push_back('{1'b1, a, wb_base + 32'(k), k});
            ref_mem[int'(a[9:0])] = wb_base + 32'(k);
          end
        for (int k = 0; k < BW; k++) begin
          a = {l_m, 3'(k)};
          exp_q.push_back('{1'b0, a, ref_mem[int'(a[9:0])], k});
        end
      end
      if (busy_m) cyc++;
      if (l_valid) begin
        if (!cur.wr) begin
          exp_fwe = 1'b1;
          chk("fill_idx", 32'(FILL_IDX), cur.idx);
          chk("fill_word", FILL_WORD, cur.data);
          fill_log[cur.idx] = FILL_WORD;
          fills_this++;
        end
        if (exp_q.size() == 0) done_next = 1;
      end else if (done_next) begin
        exp_done = 1'b1; done_next = 0; was_done = 1; last_total = cyc;
        chk("latency", cyc, lat_sum + 2);
        done_cnt++;
      end
    end

    en = MEM_RE | MEM_WE;
    chk("busy", BUSY, busy_m);
    chk("done", DONE, exp_done);
    chk("fill_we", FILL_WE, exp_fwe);
    chk("re_we_mutex", MEM_RE & MEM_WE, 0);
    if (l_valid) chk("gap_after_valid", en, 0);
    if (en && p_en && !l_valid) begin
      chk("addr_stable", MEM_ADDR, p_addr);
      chk("wdata_stable", MEM_DATA_IN, p_data);
    end
    if (en) begin
      if (exp_q.size() == 0) chk("unexpected_txn", en, 0);
      else chk("txn_kind", MEM_WE, exp_q[0].wr);
    end

    memValid = 1'b0;
    if (RST || !en) wait_cnt = -1;
    else begin
      if (wait_cnt < 0) begin
        cur_lat  = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 4));
        wait_cnt = cur_lat;
      end
      wait_cnt--;
      if (wait_cnt == 0) begin
        memValid = 1'b1; wait_cnt = -1; lat_sum += cur_lat + 1;
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("txn_addr", MEM_ADDR, cur.addr);
          if (cur.wr) chk("txn_wdata", MEM_DATA_IN, cur.data);
        end else cur.wr = 1'b1;
        if (MEM_WE) resp_mem[int'(MEM_ADDR[9:0])] = MEM_DATA_IN;
        else MEM_DOUT = resp_mem[int'(MEM_ADDR[9:0])];
        if (MEM_RE && !first_rd_set) begin first_rd_addr = MEM_ADDR; first_rd_set = 1; end
      end
    end

    l_rst = RST; l_req = REQ; l_dirty = DIRTY; l_v = VICTIM_LADDR; l_m = MISS_LADDR;
    l_valid = memValid; p_en = en; p_addr = MEM_ADDR; p_data = MEM_DATA_IN;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_req(input bit d, input int v, input int m, input logic [31:0] base);
    wb_base = base; DIRTY = d; VICTIM_LADDR = LW'(v); MISS_LADDR = LW'(m); REQ = 1'b1;
    tick();
    REQ = 1'b0;
    DIRTY = 1'($urandom_range(0, 1));
    VICTIM_LADDR = LW'($urandom_range(0, 127));
    MISS_LADDR   = LW'($urandom_range(0, 127));
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) tick();
    chk("done_timeout", done_cnt, target);
  endtask

  int d0, a0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      resp_mem[i] = 32'hC0DE_0000 + 32'(i);
      ref_mem[i]  = 32'hC0DE_0000 + 32'(i);
    end
    RST = 1'b1; REQ = 1'b0; DIRTY = 1'b0; VICTIM_LADDR = '0; MISS_LADDR = '0; wb_base = '0;
    tick(); tick();
    chk("rst_busy", BUSY, 0);         chk("rst_done", DONE, 0);
    chk("rst_fill_we", FILL_WE, 0);   chk("rst_re", MEM_RE, 0);
    chk("rst_we", MEM_WE, 0);         chk("rst_wb_idx", 32'(WB_IDX), 0);
    chk("rst_fill_idx", 32'(FILL_IDX), 0); chk("rst_addr", MEM_ADDR, 0);
    chk("rst_fill_word", FILL_WORD, 0);    chk("rst_wdata", MEM_DATA_IN, 0);
    RST = 1'b0;
    tick();

    // Clean fill of line 2 with a fixed 10-cycle memory.
    lat_mode = 10; d0 = done_cnt;
    do_req(1'b0, 0, 2, 32'h0);
    wait_done(d0 + 1);
    chk("clean_first_addr", first_rd_addr, 30'h10);
    chk("clean_word0", fill_log[0], 32'hC0DE_0010);
    chk("clean_word7", fill_log[7], 32'hC0DE_0017);
    chk("clean_total", last_total, 90);

    // Dirty miss: victim line 1 written back, line 0 filled, then line 1 read back.
    lat_mode = 0; d0 = done_cnt;
    do_req(1'b1, 1, 0, 32'hA000_0000);
    wait_done(d0 + 1);
    chk("wb_mem8", resp_mem[8], 32'hA000_0000);
    chk("wb_mem15", resp_mem[15], 32'hA000_0007);
    chk("dirty_fill0", fill_log[0], 32'hC0DE_0000);
    d0 = done_cnt;
    do_req(1'b0, 0, 1, 32'h0);
    wait_done(d0 + 1);
    chk("readback3", fill_log[3], 32'hA000_0003);

    // REQ held through two transfers, MISS_LADDR moved mid-transfer.
    d0 = done_cnt; a0 = acc_cnt;
    wb_base = 32'h5500_0000; DIRTY = 1'b1; VICTIM_LADDR = LW'(9); MISS_LADDR = LW'(5); REQ = 1'b1;
    for (int i = 0; i < 100 && acc_cnt < a0 + 1; i++) tick();
    repeat (4) tick();
    MISS_LADDR = LW'(6); DIRTY = 1'b0;
    for (int i = 0; i < 3000 && acc_cnt < a0 + 2; i++) tick();
    REQ = 1'b0;
    chk("held_accepts", acc_cnt, a0 + 2);
    wait_done(d0 + 2);
    chk("held_second_line", first_rd_addr, 30'h30);

    // Reset while the 4th fill word is outstanding.
    lat_mode = 3; d0 = done_cnt;
    do_req(1'b0, 0, 20, 32'h0);
    for (int i = 0; i < 500 && !(fills_this == 3 && MEM_RE); i++) tick();
    chk("rst_window_reached", fills_this, 3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy", BUSY, 0);   chk("abort_re", MEM_RE, 0);
    chk("abort_done", DONE, 0);   chk("abort_fill_we", FILL_WE, 0);
    repeat (3) tick();
    chk("abort_no_done", done_cnt, d0);
    lat_mode = 0;
    do_req(1'b0, 0, 21, 32'h0);
    wait_done(d0 + 1);

    // Randomized misses, each issued on the first IDLE cycle after the previous DONE.
    for (int t = 0; t < 8; t++) begin
      d0 = done_cnt;
      do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
             int'($urandom_range(0, 127)), $urandom);
      wait_done(d0 + 1);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
